// File: rtl/ssd_scan_ctrl_if.sv
// CPU write bus and display pins of the seven-segment scan controller.
// The CPU side drives the master modport and the controller uses the slave modport.
interface ssd_scan_ctrl_if;
   logic       n_wr;
   logic [1:0] addr;
   logic [7:0] data_in;
   logic [6:0] seg;
   logic [3:0] dig;

   modport master (output n_wr, addr, data_in, input seg, dig);
   modport slave  (input n_wr, addr, data_in, output seg, dig);
endinterface

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed 4-digit seven-segment scan controller with ghost blanking and PWM dimming.
// Defining SSD_LZB_EN enables leading-zero blanking; without it all four digits are always shown.
module ssd_scan_ctrl #(
   parameter int PRESCALE = 1000
) (
   input  logic            clk,
   input  logic            n_reset,
   ssd_scan_ctrl_if.slave  bus
);
   localparam int PRESC_W = $clog2(PRESCALE);
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE - 1);

   localparam logic [1:0] ST_BLANK = 2'd0;
   localparam logic [1:0] ST_ON    = 2'd1;
   localparam logic [1:0] ST_OFF   = 2'd2;

   logic               n_wr_meta_r;
   logic               n_wr_sync_r;
   logic               n_wr_prev_r;
   logic               wr_s;
   logic [15:0]        value_r;
   logic [3:0]         bright_r;
   logic [15:0]        shadow_value_r;
   logic [3:0]         shadow_bright_r;
   logic [PRESC_W-1:0] presc_r;
   logic               tick_s;
   logic               slot_end_s;
   logic [3:0]         tick_idx_r;
   logic [1:0]         state_r;
   logic [1:0]         state_s;
   logic [1:0]         digit_r;
   logic [1:0]         digit_s;
   logic [3:0]         nibble_s;
   logic               lz_s;
   logic [6:0]         seg_r;
   logic [6:0]         seg_s;
   logic [3:0]         dig_r;
   logic [3:0]         dig_s;

   function automatic logic [6:0] hex_font(input logic [3:0] nib);
      logic [6:0] f;
      case (nib)
         4'h0:    f = 7'h3F;
         4'h1:    f = 7'h06;
         4'h2:    f = 7'h5B;
         4'h3:    f = 7'h4F;
         4'h4:    f = 7'h66;
         4'h5:    f = 7'h6D;
         4'h6:    f = 7'h7D;
         4'h7:    f = 7'h07;
         4'h8:    f = 7'h7F;
         4'h9:    f = 7'h6F;
         4'hA:    f = 7'h77;
         4'hB:    f = 7'h7C;
         4'hC:    f = 7'h39;
         4'hD:    f = 7'h5E;
         4'hE:    f = 7'h79;
         4'hF:    f = 7'h71;
         default: f = 7'h00;
      endcase
      return f;
   endfunction

   // Strobe synchronizer; idles high so reset never fakes a write edge.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         n_wr_meta_r <= 1'b1;
         n_wr_sync_r <= 1'b1;
         n_wr_prev_r <= 1'b1;
      end else begin
         n_wr_meta_r <= bus.n_wr;
         n_wr_sync_r <= n_wr_meta_r;
         n_wr_prev_r <= n_wr_sync_r;
      end
   end

   assign wr_s       = n_wr_sync_r & ~n_wr_prev_r;
   assign tick_s     = (presc_r == PRESC_MAX);
   assign slot_end_s = tick_s && (tick_idx_r == 4'd15);

   // CPU-visible registers, committed on the synchronized rising strobe.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         value_r  <= 16'h0000;
         bright_r <= 4'hF;
      end else if (wr_s) begin
         case (bus.addr)
            2'd0:    value_r[7:0]  <= bus.data_in;
            2'd1:    value_r[15:8] <= bus.data_in;
            2'd2:    bright_r      <= bus.data_in[3:0];
            default: ;
         endcase
      end
   end

   // Next scan state and digit; everything moves only on tick cycles.
   always_comb begin
      state_s = state_r;
      digit_s = digit_r;
      if (slot_end_s) begin
         state_s = ST_BLANK;
         digit_s = digit_r + 2'd1;
      end else if (tick_s) begin
         case (state_r)
            ST_BLANK: state_s = (shadow_bright_r != 4'd0) ? ST_ON : ST_OFF;
            ST_ON:    state_s = (tick_idx_r == shadow_bright_r) ? ST_OFF : ST_ON;
            default:  state_s = ST_OFF;
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // Drive values for the state being entered, so the pins switch with the state.
   always_comb begin
      case (digit_r)
         2'd0:    nibble_s = shadow_value_r[3:0];
         2'd1:    nibble_s = shadow_value_r[7:4];
         2'd2:    nibble_s = shadow_value_r[11:8];
         2'd3:    nibble_s = shadow_value_r[15:12];
         default: nibble_s = 4'h0;
      endcase
`ifdef SSD_LZB_EN
      case (digit_r)
         2'd1:    lz_s = (shadow_value_r[15:4] == 12'h000);
         2'd2:    lz_s = (shadow_value_r[15:8] == 8'h00);
         2'd3:    lz_s = (shadow_value_r[15:12] == 4'h0);
         default: lz_s = 1'b0;
      endcase
`else
      lz_s = 1'b0;
`endif
      if ((state_s == ST_ON) && !lz_s) begin
         dig_s = 4'b0001 << digit_r;
         seg_s = hex_font(nibble_s);
      end else begin
         dig_s = 4'b0000;
         seg_s = 7'h00;
      end
   end

   // Prescaler, slot sequencing, shadow capture at slot start and registered pins.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         presc_r         <= {PRESC_W{1'b0}};
         tick_idx_r      <= 4'd0;
         state_r         <= ST_BLANK;
         digit_r         <= 2'd0;
         shadow_value_r  <= 16'h0000;
         shadow_bright_r <= 4'hF;
         seg_r           <= 7'h00;
         dig_r           <= 4'b0000;
      end else begin
         presc_r <= tick_s ? {PRESC_W{1'b0}} : presc_r + PRESC_W'(1);
         if (tick_s) begin
            tick_idx_r <= tick_idx_r + 4'd1;
         end
         if (slot_end_s) begin
            shadow_value_r  <= value_r;
            shadow_bright_r <= bright_r;
         end
         state_r <= state_s;
         digit_r <= digit_s;
         seg_r   <= seg_s;
         dig_r   <= dig_s;
      end
   end

   assign bus.seg = seg_r;
   assign bus.dig = dig_r;
endmodule

// File: doc/ssd_scan_ctrl.md
# ssd_scan_ctrl

Multiplexed scan controller for a 4-digit common-cathode seven-segment display on the Z80 I/O bus. Holds a 16-bit display value and a brightness setting written by the CPU, then sequences the digits with a per-slot ghost-blanking interval and PWM dimming. Sits between the CPU write strobe/data bus and the board display pins, replacing direct per-digit drive.

## Interface
- PRESCALE, 1000: clk cycles per scan tick; legal range ≥ 2.
- clk  input  1  system clock; all state on rising edge.
- n_reset  input  1  asynchronous active-low reset.
- n_wr  input  1  CPU write strobe, active low, asynchronous to clk; a write commits on its rising edge.
- addr  input  2  register select: 0 = value[7:0], 1 = value[15:8], 2 = brightness (data_in[3:0]), 3 = reserved, writes ignored.
- data_in  input  8  write data.
- seg  output  7  segment drive, active high, bit0 = a … bit6 = g.
- dig  output  4  digit enable, one-hot active high, dig[0] = least significant nibble; all-zero when blank.

## Operation
- Write path: n_wr passes through a 2-flop synchronizer. A 0→1 transition on the synchronized strobe is one write. addr and data_in are sampled on that cycle.
- Bus rule: addr and data_in stay stable from n_wr falling until 3 clk after n_wr rising. n_wr low time ≥ 2 clk.
- Registers: value_reg[15:0] resets to 0x0000. bright_reg[3:0] resets to 0xF.
- Shadow: value_reg and bright_reg are copied into shadow registers at the start of each digit slot (the BLANK entry). A write therefore never changes a digit mid-slot.
- Prescaler: counter 0..PRESCALE-1. tick = 1 for one cycle when the counter is PRESCALE-1; the counter then wraps to 0.
- Slot: 16 ticks per digit, counted by tick_idx 0..15.
- FSM states: BLANK, ON, OFF. All transitions happen only on tick cycles.
  - BLANK (tick_idx 0): dig = 0, seg = 0. On tick: go to ON if shadow bright ≥ 1, else go to OFF.
  - ON (tick_idx 1..bright): dig = one-hot(digit), seg = hex font of the shadow nibble. On tick: go to OFF when tick_idx == bright.
  - OFF (remaining ticks up to 15): dig = 0, seg = 0. On tick with tick_idx == 15: go to BLANK and advance digit (wraps 3→0).
  - bright = 15 means ON occupies ticks 1..15 and OFF is skipped.
- Hex font: 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71.
- Outputs are registered and change on the clock edge of the state change.

## Timing
- Reset (asynchronous, any time): seg = 0, dig = 0, state = BLANK, digit = 0, tick_idx = 0, prescaler = 0, registers at reset values.
- Write latency: register updated 3 clk after n_wr rising. Visible at the next digit-slot start, at most 16·PRESCALE clk later per digit.
- Digit period: 16·PRESCALE clk. Full refresh: 64·PRESCALE clk.
- Back-to-back writes: each rising edge of the synchronized strobe is applied in order. Two writes to the same address keep the last one.
- A write coinciding with a shadow-copy cycle is not seen by that copy; it appears at the following slot.
- Guaranteed: dig is never nonzero in two consecutive digit slots without at least PRESCALE clk of dig = 0 between them.

## Configuration
- SSD_LZB_EN defined: leading-zero blanking.
  - Digit k (k ≥ 1) is suppressed when shadow nibbles k..3 are all zero. During the ON state of a suppressed digit, dig = 0 and seg = 0.
  - Slot timing is unchanged. Digit 0 is always shown.
- SSD_LZB_EN undefined: all four digits are always shown.

## Test plan
- Reset, then run with PRESCALE = 4 → digits scan 0..3. Each digit shows "0" (seg = 3F) during ticks 1..15. dig = 0 during tick 0 of every slot.
- Write addr0 = 0x34, addr1 = 0x12 → dig[0] shows 66, dig[1] shows 4F, dig[2] shows 5B, dig[3] shows 06. Updates land only at slot boundaries.
- Write brightness = 4 → ON lasts exactly 4 ticks (16 clk at PRESCALE = 4) per slot. Brightness = 0 → dig stays 0 continuously.
- Write addr3 = 0xFF → no register changes. A write issued mid-slot → the current digit's seg is unchanged until the next BLANK.
- Assert n_reset mid-ON → seg and dig go to 0 immediately. After release, scanning restarts at digit 0, BLANK.
- With SSD_LZB_EN and value = 0x0050 → dig[3] and dig[2] are never asserted. dig[1] shows 6D and dig[0] shows 3F. Value 0x0000 → only dig[0] is asserted.
